// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the RV32I ALU control sequencer.
// Opcodes, funct fields, ALU control codes and FSM state.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // {ainv, binv, sel[1:0]}
  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BR
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH
  } cls_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       srcb_imm;
    cls_t       cls;
    logic       illegal;
  } dec_t;

  // funct3 -> {supported, alu ctrl} for the shared R/I arithmetic set
  function automatic logic [4:0] f3_ctrl(
    input logic [2:0] f3
  );
    logic [4:0] r;
    r = {1'b0, ALUC_AND};
    unique case (f3)
      F3_ADD:  r = {1'b1, ALUC_ADD};
      F3_AND:  r = {1'b1, ALUC_AND};
      F3_OR:   r = {1'b1, ALUC_OR};
      F3_SLT:  r = {1'b1, ALUC_SLT};
      default: r = {1'b0, ALUC_AND};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_alu_ctrl_fsm_if.sv
// Instruction offer handshake between fetch and the control sequencer.
// master offers the instruction, slave accepts it.
interface riscv_alu_ctrl_fsm_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/riscv_alu_decode.sv
// Combinational RV32I subset decoder.
// Maps opcode/funct fields to ALU control, operand select and class.
module riscv_alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  logic [4:0] fc;

  always_comb begin
    fc  = f3_ctrl(funct3);
    dec = '{ctrl: ALUC_AND, srcb_imm: 1'b0,
            cls: CL_ALU, illegal: 1'b1};
    unique case (1'b1)
      (opcode == OP_R): begin
        if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.ctrl    = ALUC_SUB;
          dec.illegal = 1'b0;
        end else if (funct7 == F7_BASE && fc[4]) begin
          dec.ctrl    = fc[3:0];
          dec.illegal = 1'b0;
        end
      end
      (opcode == OP_I): begin
        if (fc[4]) begin
          dec.ctrl     = fc[3:0];
          dec.srcb_imm = 1'b1;
          dec.illegal  = 1'b0;
        end
      end
      (opcode == OP_LOAD): begin
        if (funct3 == F3_W) begin
          dec.ctrl     = ALUC_ADD;
          dec.srcb_imm = 1'b1;
          dec.cls      = CL_LOAD;
          dec.illegal  = 1'b0;
        end
      end
      (opcode == OP_STORE): begin
        if (funct3 == F3_W) begin
          dec.ctrl     = ALUC_ADD;
          dec.srcb_imm = 1'b1;
          dec.cls      = CL_STORE;
          dec.illegal  = 1'b0;
        end
      end
      (opcode == OP_BRANCH): begin
        if (funct3 == F3_BEQ) begin
          dec.ctrl    = ALUC_SUB;
          dec.cls     = CL_BRANCH;
          dec.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_alu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer driving ALU, RF, memory
// and PC strobes through DECODE/EXEC/MEM/WB/BR.
module riscv_alu_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_alu_ctrl_fsm_if.slave  ibus,
  output logic                 alu_ainv,
  output logic                 alu_binv,
  output logic [1:0]           alu_sel,
  output logic                 alu_srcb_imm,
  input  logic                 alu_zero,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic                 rf_we,
  output logic                 rf_wsel,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 illegal,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     retired
);

  localparam int unsigned TW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  logic [6:0]       ir_op;
  logic [2:0]       ir_f3;
  logic [6:0]       ir_f7;
  dec_t             dec;
  logic [3:0]       ctrl_q;
  logic             srcb_q;
  logic             ready_q;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] ret_q;
  logic             accept;
  logic             expire;
  logic             done;

  riscv_alu_decode u_dec (
    .opcode (ir_op),
    .funct3 (ir_f3),
    .funct7 (ir_f7),
    .dec    (dec)
  );

  assign accept           = ibus.instr_valid & ready_q;
  assign expire           = (tcnt == TLAST);
  assign ibus.instr_ready = ready_q;
  assign alu_ainv         = ctrl_q[3];
  assign alu_binv         = ctrl_q[2];
  assign alu_sel          = ctrl_q[1:0];
  assign alu_srcb_imm     = srcb_q;
  assign retired          = ret_q;

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    rf_wsel = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (dec.illegal) begin
          illegal = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (dec.cls)
          CL_ALU:    state_n = S_WB;
          CL_BRANCH: state_n = S_BR;
          default:   state_n = S_MEM;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec.cls == CL_STORE);
        // an ack on the expiry cycle still completes
        if (mem_ack) begin
          if (dec.cls == CL_STORE) begin
            pc_we   = 1'b1;
            done    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WB;
          end
        end else if (expire) begin
          mem_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = (dec.cls == CL_LOAD);
        pc_we   = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_BR: begin
        pc_we   = 1'b1;
        pc_src  = alu_zero;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir_op   <= '0;
      ir_f3   <= '0;
      ir_f7   <= '0;
      ctrl_q  <= '0;
      srcb_q  <= 1'b0;
      ready_q <= 1'b0;
      tcnt    <= '0;
      ret_q   <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == S_IDLE);
      if (state == S_IDLE && accept) begin
        ir_op <= ibus.instr[6:0];
        ir_f3 <= ibus.instr[14:12];
        ir_f7 <= ibus.instr[31:25];
      end
      if (state == S_DECODE && state_n == S_EXEC) begin
        ctrl_q <= dec.ctrl;
        srcb_q <= dec.srcb_imm;
      end else if (state_n == S_IDLE) begin
        ctrl_q <= '0;
        srcb_q <= 1'b0;
      end
      if (state == S_MEM && state_n == S_MEM) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
      if (done) ret_q <= ret_q + CNT_W'(1);
    end
  end

endmodule
